slow_tick_seq: RTL and testbench

//  Consumes the divided slow_clk level and converts each of its rising edges into a

---
 rtl/slow_tick_seq.sv | 127 ++++++++++++
 tb/tb_slow_tick_seq.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_tick_seq.sv
// slow_tick_seq: turns rising edges of the divided slow_clk level into single-cycle
// step pulses and paces a row-major walk over an N x N matrix, one element per edge.
module slow_tick_seq #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             slow_clk,
   input  logic             start,
   output logic             step,
   output logic [IDX_W-1:0] row,
   output logic [IDX_W-1:0] col,
   output logic             last,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(N - 1);

   logic s1_q, s2_q, s3_q;
   logic tick;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] r_q, r_d, c_q, c_d;
   logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
   logic             step_q, step_d;
   logic             last_q, last_d;
   logic             done_q, done_d;

   // Synchroniser plus edge-history flop; preset high so a level already high at
   // reset release is not mistaken for a rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= slow_clk;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign tick = s2_q & ~s3_q;

   // State, walk indices and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         r_q     <= '0;
         c_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         step_q  <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         c_q     <= c_d;
         row_q   <= row_d;
         col_q   <= col_d;
         step_q  <= step_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: walk advances only on a tick while running.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      row_d   = row_q;
      col_d   = col_q;
      last_d  = last_q;
      step_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            // A tick coinciding with start is deliberately not consumed here.
            if (start) begin
               state_d = StRun;
               r_d     = '0;
               c_d     = '0;
               last_d  = 1'b0;
            end
         end
         StRun: begin
            if (tick) begin
               step_d = 1'b1;
               row_d  = r_q;
               col_d  = c_q;
               last_d = (r_q == MaxIdx) && (c_q == MaxIdx);
               if (c_q == MaxIdx) begin
                  c_d = '0;
                  if (r_q == MaxIdx) begin
                     r_d     = '0;
                     state_d = StFin;
                  end else begin
                     r_d = r_q + 1'b1;
                  end
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end
         StFin: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign step = step_q;
   assign row  = row_q;
   assign col  = col_q;
   assign last = last_q;
   assign done = done_q;
   // FIN overlaps the final step, so busy drops exactly when done rises.
   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_slow_tick_seq.sv
// tb_slow_tick_seq: scoreboard bench for slow_tick_seq (N=3).
module tb_slow_tick_seq;

   localparam int N     = 3;
   localparam int IDX_W = 2;

   logic             clk, rst, slow_clk, start;
   logic             step, last, busy, done;
   logic [IDX_W-1:0] row, col;

   typedef struct {
      logic [IDX_W-1:0] row;
      logic [IDX_W-1:0] col;
      logic             last;
   } ent_t;

   typedef struct {
      logic [IDX_W-1:0] row;
      logic [IDX_W-1:0] col;
      logic             last;
      int               cyc;
   } obs_t;

   ent_t exp_q[$];
   obs_t obs_q[$];
   int   done_q[$];
   logic done_busy_q[$];

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   slow_half = 5;
   logic slow_hold = 1'b1;
   int   slow_cnt = 0;

   slow_tick_seq #(.N(N), .IDX_W(IDX_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .slow_clk (slow_clk),
      .start    (start),
      .step     (step),
      .row      (row),
      .col      (col),
      .last     (last),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // slow_clk source: toggles every slow_half cycles, or holds slow_hold when slow_half is 0
   initial begin
      slow_clk = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (slow_half != 0) begin
            slow_cnt++;
            if (slow_cnt >= slow_half) begin
               slow_cnt = 0;
               slow_clk = ~slow_clk;
            end
         end else begin
            slow_cnt = 0;
            slow_clk = slow_hold;
         end
      end
   end

   // Monitor: capture every step and done pulse
   always @(negedge clk) begin
      if (step) obs_q.push_back('{row, col, last, cyc});
      if (done) begin
         done_q.push_back(cyc);
         done_busy_q.push_back(busy);
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      exp_q.delete();
      obs_q.delete();
      done_q.delete();
      done_busy_q.delete();
   endtask

   task automatic push_walk();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            exp_q.push_back('{IDX_W'(r), IDX_W'(c), (r == N - 1) && (c == N - 1)});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick_n(1);
      start = 1'b0;
   endtask

   task automatic wait_obs(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (done_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      slow_half = 5;
      tick_n(3);
      @(negedge clk);
      total++;
      if ({step, busy, done, last, row, col} !== 8'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 00000000", {step, busy, done, last, row, col});
      end
      tick_n(1);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         total++;
         if ({step, busy, done, row, col} !== 7'b0) begin
            bad++;
            $display("FAIL idle_quiet cycle %0d: got %b want 0000000", i,
                     {step, busy, done, row, col});
         end
      end
   endtask

   task automatic test_walk();
      bit   ok;
      ent_t e;
      clear_q();
      tick_n(1);
      push_walk();
      pulse_start();
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_after_start: got %b want 1", busy);
      end
      wait_obs(5, 200, ok);
      // start mid-walk must be ignored
      pulse_start();
      wait_done(1, 300, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL walk_timeout: got no done want done");
      end
      tick_n(40);
      total++;
      if (obs_q.size() !== 9) begin
         bad++;
         $display("FAIL walk_step_count: got %0d want 9", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_q[i].row, obs_q[i].col, obs_q[i].last} !== {e.row, e.col, e.last}) begin
            bad++;
            $display("FAIL walk_step%0d: got r%0d c%0d l%b want r%0d c%0d l%b", i,
                     obs_q[i].row, obs_q[i].col, obs_q[i].last, e.row, e.col, e.last);
         end
      end
      total++;
      if (done_q.size() !== 1) begin
         bad++;
         $display("FAIL walk_done_count: got %0d want 1", done_q.size());
      end
      if (obs_q.size() == 9 && done_q.size() == 1) begin
         total++;
         if (done_q[0] !== obs_q[8].cyc + 1) begin
            bad++;
            $display("FAIL done_timing: got cycle %0d want %0d", done_q[0], obs_q[8].cyc + 1);
         end
         total++;
         if (done_busy_q[0] !== 1'b0) begin
            bad++;
            $display("FAIL busy_at_done: got %b want 0", done_busy_q[0]);
         end
         total++;
         if (obs_q[1].cyc - obs_q[0].cyc !== 10) begin
            bad++;
            $display("FAIL step_period: got %0d want 10", obs_q[1].cyc - obs_q[0].cyc);
         end
      end
   endtask

   task automatic test_high_at_reset();
      bit   ok;
      int   c0;
      ent_t e;
      slow_half = 0;
      slow_hold = 1'b1;
      rst = 1'b1;
      tick_n(4);
      rst = 1'b0;
      clear_q();
      push_walk();
      pulse_start();
      tick_n(30);
      total++;
      if (obs_q.size() !== 0) begin
         bad++;
         $display("FAIL step_while_high: got %0d steps want 0", obs_q.size());
      end
      slow_hold = 1'b0;
      tick_n(5);
      slow_hold = 1'b1;
      c0 = cyc;
      wait_obs(1, 20, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL high_reset_timeout: got no step want step");
      end else begin
         e = exp_q.pop_front();
         total++;
         if ({obs_q[0].row, obs_q[0].col, obs_q[0].last} !== {e.row, e.col, e.last}) begin
            bad++;
            $display("FAIL high_reset_first: got r%0d c%0d l%b want r%0d c%0d l%b",
                     obs_q[0].row, obs_q[0].col, obs_q[0].last, e.row, e.col, e.last);
         end
         total++;
         if (obs_q[0].cyc !== c0 + 3) begin
            bad++;
            $display("FAIL step_latency: got cycle %0d want %0d", obs_q[0].cyc, c0 + 3);
         end
      end
      rst = 1'b1;
      tick_n(1);
      rst = 1'b0;
      clear_q();
   endtask

   task automatic test_reset_mid();
      bit   ok;
      ent_t e;
      slow_half = 5;
      clear_q();
      push_walk();
      pulse_start();
      wait_obs(4, 200, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL mid_timeout: got %0d steps want 4", obs_q.size());
      end
      rst = 1'b1;
      tick_n(1);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({step, busy, done, last, row, col} !== 8'b0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got %b want 00000000",
                  {step, busy, done, last, row, col});
      end
      tick_n(40);
      total++;
      if (obs_q.size() !== 4 || done_q.size() !== 0) begin
         bad++;
         $display("FAIL after_abort: got %0d steps %0d done want 4 steps 0 done",
                  obs_q.size(), done_q.size());
      end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_q[i].row, obs_q[i].col, obs_q[i].last} !== {e.row, e.col, e.last}) begin
            bad++;
            $display("FAIL abort_step%0d: got r%0d c%0d l%b want r%0d c%0d l%b", i,
                     obs_q[i].row, obs_q[i].col, obs_q[i].last, e.row, e.col, e.last);
         end
      end
      clear_q();
      push_walk();
      pulse_start();
      wait_done(1, 300, ok);
      total++;
      if (!ok || obs_q.size() !== 9) begin
         bad++;
         $display("FAIL restart_walk: got %0d steps done=%b want 9 steps done=1",
                  obs_q.size(), ok);
      end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_q[i].row, obs_q[i].col, obs_q[i].last} !== {e.row, e.col, e.last}) begin
            bad++;
            $display("FAIL restart_step%0d: got r%0d c%0d l%b want r%0d c%0d l%b", i,
                     obs_q[i].row, obs_q[i].col, obs_q[i].last, e.row, e.col, e.last);
         end
      end
   endtask

   task automatic test_start_on_tick();
      bit   ok;
      ent_t e;
      slow_half = 0;
      slow_hold = 1'b0;
      tick_n(6);
      clear_q();
      slow_hold = 1'b1;
      tick_n(2);
      // tick is live during this cycle; start sampled on the same edge
      pulse_start();
      tick_n(10);
      total++;
      if (obs_q.size() !== 0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL start_on_tick: got %0d steps busy=%b want 0 steps busy=1",
                  obs_q.size(), busy);
      end
      slow_hold = 1'b0;
      tick_n(5);
      push_walk();
      slow_half = 5;
      wait_done(1, 300, ok);
      total++;
      if (!ok || obs_q.size() !== 9) begin
         bad++;
         $display("FAIL tick_walk: got %0d steps done=%b want 9 steps done=1",
                  obs_q.size(), ok);
      end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_q[i].row, obs_q[i].col, obs_q[i].last} !== {e.row, e.col, e.last}) begin
            bad++;
            $display("FAIL tick_step%0d: got r%0d c%0d l%b want r%0d c%0d l%b", i,
                     obs_q[i].row, obs_q[i].col, obs_q[i].last, e.row, e.col, e.last);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit   ok;
      ent_t e;
      slow_half = 5;
      tick_n(2);
      clear_q();
      push_walk();
      push_walk();
      start = 1'b1;
      wait_done(2, 600, ok);
      start = 1'b0;
      tick_n(40);
      total++;
      if (!ok || done_q.size() !== 2 || obs_q.size() !== 18) begin
         bad++;
         $display("FAIL b2b_counts: got %0d steps %0d done want 18 steps 2 done",
                  obs_q.size(), done_q.size());
      end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         total++;
         if ({obs_q[i].row, obs_q[i].col, obs_q[i].last} !== {e.row, e.col, e.last}) begin
            bad++;
            $display("FAIL b2b_step%0d: got r%0d c%0d l%b want r%0d c%0d l%b", i,
                     obs_q[i].row, obs_q[i].col, obs_q[i].last, e.row, e.col, e.last);
         end
      end
      if (obs_q.size() == 18 && done_q.size() == 2) begin
         total++;
         if (!(obs_q[9].cyc > done_q[0] && done_q[1] == obs_q[17].cyc + 1)) begin
            bad++;
            $display("FAIL b2b_order: got step9 %0d done0 %0d done1 %0d want step9>done0",
                     obs_q[9].cyc, done_q[0], done_q[1]);
         end
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle: got busy=%b want 0", busy);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      test_reset();
      test_walk();
      test_high_at_reset();
      test_reset_mid();
      test_start_on_tick();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
